alu_arbiter: RTL and testbench

//  Shares one alu32 instance between two requesters, e.g. port 0 = execute stage and

---
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters using round-robin
// grants, and buffers the ALU result in a one-entry register tagged with its owner.
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit RESET_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [2:0]       req_f0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_f1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             lastGrant_q, lastGrant_d;
    logic [WIDTH-1:0] rspY_q, rspY_d;
    logic             rspZero_q, rspZero_d;

    logic             free;
    logic             grantValid;
    logic             grantPort;

    // The buffer can take a new result when empty or when its owner drains it this cycle.
    always_comb begin
        free       = (state_q == IDLE) || rsp_ready[owner_q];
        grantPort  = (req_valid == 2'b11) ? ~lastGrant_q : req_valid[1];
        grantValid = free && (req_valid != 2'b00);
    end

    always_comb begin
        req_ready = 2'b00;
        alu_a     = '0;
        alu_b     = '0;
        alu_f     = 3'b000;
        if (grantValid) begin
            if (grantPort) begin
                req_ready = 2'b10;
                alu_a     = req_a1;
                alu_b     = req_b1;
                alu_f     = req_f1;
            end else begin
                req_ready = 2'b01;
                alu_a     = req_a0;
                alu_b     = req_b0;
                alu_f     = req_f0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        rspY_d      = rspY_q;
        rspZero_d   = rspZero_q;
        if (grantValid) begin
            state_d     = HOLD;
            owner_d     = grantPort;
            lastGrant_d = grantPort;
            rspY_d      = alu_y;
            rspZero_d   = alu_zero;
        end else if (free) begin
            state_d = IDLE;
        end
    end

    // Reset wins over a same-cycle grant, so an in-flight operation is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastGrant_q <= ~RESET_PRI;
            rspY_q      <= '0;
            rspZero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            rspY_q      <= rspY_d;
            rspZero_q   <= rspZero_d;
        end
    end

    assign rsp_valid = (state_q == HOLD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_y     = rspY_q;
    assign rsp_zero  = rspZero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus against alu_arbiter with a queue-based reference
// model checked every cycle, plus hand-computed expectations for each scenario.
module tb_alu_arbiter;

    localparam int WIDTH     = 32;
    localparam bit RESET_PRI = 1'b0;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [WIDTH-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic [2:0]        req_f0, req_f1;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_y;
    logic [2:0]        alu_f;
    logic              alu_zero;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [WIDTH-1:0]  rsp_y;
    logic              rsp_zero;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic        owner;
        logic [31:0] y;
        logic        zero;
    } result_t;

    result_t pendQ[$];
    logic    lastGrant;
    bit      modelArmed = 1'b0;

    logic        cmpGv, cmpG, mdlGv, mdlG;
    logic [1:0]  expReady, expRspValid;
    logic [31:0] mdlA, mdlB, mdlY;
    logic [2:0]  mdlF;

    alu_arbiter #(.WIDTH(WIDTH), .RESET_PRI(RESET_PRI)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_f0(req_f0),
        .req_a1(req_a1), .req_b1(req_b1), .req_f1(req_f1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    // Reference ALU: F[2] selects B inversion, F[1:0] picks AND/OR/ADD/SLT.
    function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
        logic [31:0] bb;
        bb = f[2] ? ~b : b;
        case (f[1:0])
            2'b00:   return a & bb;
            2'b01:   return a | bb;
            2'b10:   return f[2] ? (a - b) : (a + b);
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign alu_y    = aluRef(alu_a, alu_b, alu_f);
    assign alu_zero = (alu_y == 32'd0);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Arbitration decision from the pending-result queue and the current requests.
    function automatic void modelGrant(output logic gv, output logic g);
        logic canTake;
        canTake = (pendQ.size() == 0) || rsp_ready[pendQ[0].owner];
        g  = (req_valid == 2'b11) ? ~lastGrant : req_valid[1];
        gv = canTake && (req_valid != 2'b00);
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            pendQ.delete();
            lastGrant  = ~RESET_PRI;
            modelArmed = 1'b1;
        end else if (modelArmed) begin
            modelGrant(mdlGv, mdlG);
            if (pendQ.size() != 0 && rsp_ready[pendQ[0].owner])
                void'(pendQ.pop_front());
            if (mdlGv) begin
                mdlA = mdlG ? req_a1 : req_a0;
                mdlB = mdlG ? req_b1 : req_b0;
                mdlF = mdlG ? req_f1 : req_f0;
                mdlY = aluRef(mdlA, mdlB, mdlF);
                pendQ.push_back('{owner: mdlG, y: mdlY, zero: (mdlY == 32'd0)});
                lastGrant = mdlG;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the edge.
    always @(negedge clk) begin
        if (modelArmed) begin
            modelGrant(cmpGv, cmpG);
            expReady = cmpGv ? (2'b01 << cmpG) : 2'b00;
            checkOutput("model req_ready", 32'(req_ready), 32'(expReady));
            checkOutput("model alu_a", alu_a, cmpGv ? (cmpG ? req_a1 : req_a0) : 32'd0);
            checkOutput("model alu_b", alu_b, cmpGv ? (cmpG ? req_b1 : req_b0) : 32'd0);
            checkOutput("model alu_f", 32'(alu_f), cmpGv ? 32'(cmpG ? req_f1 : req_f0) : 32'd0);
            expRspValid = (pendQ.size() == 0) ? 2'b00 : (2'b01 << pendQ[0].owner);
            checkOutput("model rsp_valid", 32'(rsp_valid), 32'(expRspValid));
            if (pendQ.size() != 0) begin
                checkOutput("model rsp_y", rsp_y, pendQ[0].y);
                checkOutput("model rsp_zero", 32'(rsp_zero), 32'(pendQ[0].zero));
            end
        end
    end

    // Drive one cycle of inputs just after the edge, then settle before literal checks.
    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] ready,
                                 input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [2:0] f0,
                                 input logic [31:0] a1, input logic [31:0] b1,
                                 input logic [2:0] f1);
        @(posedge clk);
        #1;
        req_valid = valid;
        rsp_ready = ready;
        req_a0 = a0; req_b0 = b0; req_f0 = f0;
        req_a1 = a1; req_b1 = b1; req_f1 = f1;
        #2;
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
    endtask

    initial begin
        req_a0 = '0; req_b0 = '0; req_f0 = '0;
        req_a1 = '0; req_b1 = '0; req_f1 = '0;

        $display("[TB] reset and single port-0 add");
        resetDut();
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset rsp_y", rsp_y, 32'h0);
        checkOutput("reset rsp_zero", 32'(rsp_zero), 32'h0);
        applyStimulus(2'b01, 2'b01, 32'd5, 32'd7, 3'b010, 32'd0, 32'd0, 3'b000);
        checkOutput("t1 req_ready", 32'(req_ready), 32'h1);
        checkOutput("t1 alu_a", alu_a, 32'd5);
        applyStimulus(2'b00, 2'b01, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 3'b000);
        checkOutput("t1 rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t1 rsp_y", rsp_y, 32'd12);
        checkOutput("t1 rsp_zero", 32'(rsp_zero), 32'h0);

        $display("[TB] contention alternates grants");
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b11, 32'd9, 32'd9, 3'b110, 32'd3, 32'd4, 3'b111);
            checkOutput("t2 req_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) begin
                checkOutput("t2 rsp_y", rsp_y, (i % 2 == 1) ? 32'd0 : 32'd1);
                checkOutput("t2 rsp_zero", 32'(rsp_zero), (i % 2 == 1) ? 32'h1 : 32'h0);
            end
        end
        applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 3'b000);
        checkOutput("t2 last rsp_valid", 32'(rsp_valid), 32'h2);
        checkOutput("t2 last rsp_y", rsp_y, 32'd1);

        $display("[TB] stall on port-1 result");
        applyStimulus(2'b10, 2'b00, 32'd0, 32'd0, 3'b000, 32'd0, 32'd1, 3'b110);
        checkOutput("t3 grant port1", 32'(req_ready), 32'h2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 2'b00, 32'd2, 32'd3, 3'b010, 32'd0, 32'd1, 3'b110);
            checkOutput("t3 stall rsp_valid", 32'(rsp_valid), 32'h2);
            checkOutput("t3 stall rsp_y", rsp_y, 32'hFFFF_FFFF);
            checkOutput("t3 stall req_ready", 32'(req_ready), 32'h0);
            checkOutput("t3 stall alu_a", alu_a, 32'h0);
        end
        applyStimulus(2'b01, 2'b10, 32'd2, 32'd3, 3'b010, 32'd0, 32'd1, 3'b110);
        checkOutput("t3 release req_ready", 32'(req_ready), 32'h1);
        applyStimulus(2'b00, 2'b01, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 3'b000);
        checkOutput("t3 port0 rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t3 port0 rsp_y", rsp_y, 32'd5);

        $display("[TB] streaming on port 0");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b01, 2'b01, 32'(i * 3 + 1), 32'(i + 100), 3'b010,
                          32'd0, 32'd0, 3'b000);
            checkOutput("t4 req_ready", 32'(req_ready), 32'h1);
            if (i > 0) begin
                checkOutput("t4 rsp_valid", 32'(rsp_valid), 32'h1);
                checkOutput("t4 rsp_y", rsp_y, 32'((i - 1) * 3 + 1 + (i - 1) + 100));
            end
        end
        applyStimulus(2'b00, 2'b01, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 3'b000);
        checkOutput("t4 last rsp_y", rsp_y, 32'd129);

        $display("[TB] reset while holding a result");
        applyStimulus(2'b01, 2'b00, 32'd20, 32'd22, 3'b110, 32'd0, 32'd0, 3'b000);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 2'b10;
        req_a1 = 32'd7; req_b1 = 32'd8; req_f1 = 3'b010;
        #2;
        checkOutput("t5 hold before reset", 32'(rsp_valid), 32'h1);
        checkOutput("t5 held rsp_y", rsp_y, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 2'b00;
        #2;
        checkOutput("t5 post-reset rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("t5 post-reset rsp_y", rsp_y, 32'h0);
        applyStimulus(2'b00, 2'b11, 32'd0, 32'd0, 3'b000, 32'd0, 32'd0, 3'b000);
        checkOutput("t5 no capture", 32'(rsp_valid), 32'h0);

        $display("[TB] idle");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b00, 2'b00, 32'd11, 32'd12, 3'b011, 32'd13, 32'd14, 3'b101);
            checkOutput("t6 alu_a", alu_a, 32'h0);
            checkOutput("t6 alu_b", alu_b, 32'h0);
            checkOutput("t6 alu_f", 32'(alu_f), 32'h0);
            checkOutput("t6 req_ready", 32'(req_ready), 32'h0);
            checkOutput("t6 rsp_valid", 32'(rsp_valid), 32'h0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
